// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination scoreboard for the in-order integer
// pipeline. Tracks DEPTH entries shadowing EX..WB, forwards ready results to
// NREAD decode read ports, raises the load-use stall and kills younger
// entries on a control-flow redirect.

// Per read port forwarding: youngest matching entry wins. A not-ready winner
// blocks the port even when an older entry holds a ready copy of the register.
module hazard_scoreboard_port #(
    parameter int DEPTH = 3,
    parameter int REGW  = 5,
    parameter int DATAW = 64
) (
    input  logic [DEPTH-1:0]            ent_valid,
    input  logic [DEPTH-1:0]            ent_wen,
    input  logic [DEPTH-1:0]            ent_ready,
    input  logic [DEPTH-1:0][REGW-1:0]  ent_rd,
    input  logic [DEPTH-1:0][DATAW-1:0] ent_data,
    input  logic [REGW-1:0]             rs_idx,
    input  logic [DATAW-1:0]            rf_data,
    output logic [DATAW-1:0]            rs_data,
    output logic                        blocked
);

    // Walk oldest to youngest so the lowest matching index has the last word.
    always_comb begin
        rs_data = rf_data;
        blocked = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && ent_wen[i] && (ent_rd[i] == rs_idx) && (rs_idx != '0)) begin
                rs_data = ent_ready[i] ? ent_data[i] : rf_data;
                blocked = ~ent_ready[i];
            end
        end
    end

endmodule

module hazard_scoreboard #(
    parameter int DEPTH     = 3,
    parameter int NREAD     = 2,
    parameter int REGW      = 5,
    parameter int DATAW     = 64,
    parameter int FLUSH_IDX = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   advance,
    input  logic                   issue_valid,
    input  logic [REGW-1:0]        issue_rd,
    input  logic                   issue_wen,
    input  logic                   issue_load,
    input  logic [DEPTH-1:0]       res_valid,
    input  logic [DEPTH*DATAW-1:0] res_data,
    input  logic                   flush_en,
    input  logic [NREAD*REGW-1:0]  rs_idx,
    input  logic [NREAD*DATAW-1:0] rf_data,
    output logic [NREAD*DATAW-1:0] rs_data,
    output logic                   stall,
    output logic [31:0]            stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic [REGW-1:0]  rd;
        logic             wen;
        logic             ready;
        logic [DATAW-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q, ent_d, cap;

    logic [DEPTH-1:0]            ent_valid, ent_wen, ent_ready;
    logic [DEPTH-1:0][REGW-1:0]  ent_rd;
    logic [DEPTH-1:0][DATAW-1:0] ent_data;
    logic [NREAD-1:0]            blocked;
    logic                        adv_int;
    logic [31:0]                 stall_cnt_q, stall_cnt_d;

    // Load-use is inferred from the ready bit alone; the load flag carries no
    // extra information for the scoreboard.
    logic unused_load;
    assign unused_load = issue_load;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_valid[i] = ent_q[i].valid;
        assign ent_wen[i]   = ent_q[i].wen;
        assign ent_ready[i] = ent_q[i].ready;
        assign ent_rd[i]    = ent_q[i].rd;
        assign ent_data[i]  = ent_q[i].data;
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        hazard_scoreboard_port #(
            .DEPTH (DEPTH),
            .REGW  (REGW),
            .DATAW (DATAW)
        ) u_port (
            .ent_valid (ent_valid),
            .ent_wen   (ent_wen),
            .ent_ready (ent_ready),
            .ent_rd    (ent_rd),
            .ent_data  (ent_data),
            .rs_idx    (rs_idx[p*REGW +: REGW]),
            .rf_data   (rf_data[p*DATAW +: DATAW]),
            .rs_data   (rs_data[p*DATAW +: DATAW]),
            .blocked   (blocked[p])
        );
    end

    assign stall   = issue_valid & (|blocked);
    assign adv_int = advance & ~stall;

    // Next entry state: capture results in place, then shift (or hold), then
    // apply redirect kills. A stalled or flushed issue becomes a bubble.
    always_comb begin
        cap = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (res_valid[i] && ent_q[i].valid) begin
                cap[i].ready = 1'b1;
                cap[i].data  = res_data[i*DATAW +: DATAW];
            end
        end

        ent_d = cap;
        if (advance) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                ent_d[i] = cap[i-1];
                if (flush_en && ((i - 1) < FLUSH_IDX)) begin
                    ent_d[i].valid = 1'b0;
                end
            end
            ent_d[0] = '0;
            if (adv_int && !flush_en) begin
                ent_d[0].valid = issue_valid;
                ent_d[0].rd    = issue_rd;
                ent_d[0].wen   = issue_wen;
            end
        end else if (flush_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i < FLUSH_IDX) begin
                    ent_d[i].valid = 1'b0;
                end
            end
        end
    end

    // Count stall cycles that actually cost a bubble; redirect cycles excluded.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && advance && !flush_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
